// File: rtl/ins_fetch.sv
// Instruction fetch stage: issues sequential ROM reads, buffers returned words in a
// small prefetch queue and presents assembled 1- or 2-word instructions to the decoder.
module ins_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         rom_rd,
    output logic [15:0]                  rom_addr,
    input  logic [15:0]                  rom_data,
    input  logic                         jmp_load,
    input  logic [15:0]                  jmp_addr,
    output logic                         ins_valid,
    input  logic                         ins_ready,
    output logic [15:0]                  ins_word,
    output logic [15:0]                  ins_ext,
    output logic [1:0]                   ins_len,
    output logic [15:0]                  ins_pc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] addr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    entry_t        q     [DEPTH];
    entry_t        q_nxt [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          inflight;
    logic [15:0]   fetch_pc;
    logic [15:0]   ret_addr;

    logic          credit_c;
    logic          head_len2_c;
    logic          push_c;
    logic          pop_c;

    // Credit counts the outstanding read so the queue can never overflow.
    assign credit_c    = ((CW+1)'(cnt) + (CW+1)'(inflight)) < (CW+1)'(DEPTH);
    assign head_len2_c = (q[0].word[15:14] == 2'b10);
    assign push_c      = inflight && !jmp_load;
    assign pop_c       = ins_valid && ins_ready;

    assign rom_rd    = (state == FETCH) && en && !jmp_load && credit_c;
    assign rom_addr  = fetch_pc;
    assign ins_valid = head_len2_c ? (cnt >= CW'(2)) : (cnt != '0);
    assign ins_word  = q[0].word;
    assign ins_pc    = q[0].addr;
    assign ins_ext   = head_len2_c ? q[1].word : 16'h0000;
    assign ins_len   = head_len2_c ? 2'd2 : 2'd1;
    assign q_count   = cnt;

    // Next-state logic; a redirect overrides the normal transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = FETCH;
            FETCH:   if (!en) state_nxt = IDLE;
                     else if (!credit_c) state_nxt = HOLD;
            HOLD:    if (!en) state_nxt = IDLE;
                     else if (credit_c) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (jmp_load) state_nxt = en ? FETCH : IDLE;
    end

    // Shift-down queue: pop first, then the returning word lands at the new tail.
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        if (pop_c) begin
            if (head_len2_c) begin
                for (int i = 0; i < int'(DEPTH) - 2; i++) q_nxt[i] = q[i+2];
                q_nxt[DEPTH-2] = '0;
                q_nxt[DEPTH-1] = '0;
                cnt_nxt        = cnt - CW'(2);
            end else begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) q_nxt[i] = q[i+1];
                q_nxt[DEPTH-1] = '0;
                cnt_nxt        = cnt - CW'(1);
            end
        end
        if (push_c) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) == cnt_nxt) q_nxt[i] = '{word: rom_data, addr: ret_addr};
            end
            cnt_nxt = cnt_nxt + CW'(1);
        end
        if (jmp_load) begin
            for (int i = 0; i < int'(DEPTH); i++) q_nxt[i] = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            inflight <= 1'b0;
            fetch_pc <= RESET_PC;
            ret_addr <= 16'h0000;
            for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            q        <= q_nxt;
            inflight <= rom_rd;
            if (rom_rd) ret_addr <= fetch_pc;
            if (jmp_load)    fetch_pc <= jmp_addr;
            else if (rom_rd) fetch_pc <= fetch_pc + 16'd1;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: behavioural ROM, transfer log and cycle-exact spot checks.
module tb_ins_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        jmp_load;
    logic [15:0] jmp_addr;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_word;
    logic [15:0] ins_ext;
    logic [1:0]  ins_len;
    logic [15:0] ins_pc;
    logic [2:0]  q_count;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [65536];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
        logic [15:0] ext;
        logic [1:0]  len;
    } xfer_t;
    xfer_t xq [$];

    ins_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .jmp_load  (jmp_load),
        .jmp_addr  (jmp_addr),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_word  (ins_word),
        .ins_ext   (ins_ext),
        .ins_len   (ins_len),
        .ins_pc    (ins_pc),
        .q_count   (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: address sampled on the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (rom_rd === 1'b1) rom_data <= mem[rom_addr];
    end

    // Log every completed transfer to the decoder.
    always @(negedge clk) begin
        if (rst === 1'b0 && ins_valid === 1'b1 && ins_ready === 1'b1)
            xq.push_back('{ins_pc, ins_word, ins_ext, ins_len});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        jmp_load = 1'b0;
        jmp_addr = 16'h0000;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        xq.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rom_rd"},    32'(rom_rd),    32'h0);
        check_eq({pfx, "_rom_addr"},  32'(rom_addr),  32'h0000);
        check_eq({pfx, "_ins_valid"}, 32'(ins_valid), 32'h0);
        check_eq({pfx, "_ins_word"},  32'(ins_word),  32'h0);
        check_eq({pfx, "_ins_ext"},   32'(ins_ext),   32'h0);
        check_eq({pfx, "_ins_len"},   32'(ins_len),   32'h1);
        check_eq({pfx, "_ins_pc"},    32'(ins_pc),    32'h0);
        check_eq({pfx, "_q_count"},   32'(q_count),   32'h0);
    endtask

    initial begin
        logic [15:0] save0;
        logic [15:0] save1;
        logic [15:0] savef;
        rst       = 1'b1;
        en        = 1'b0;
        ins_ready = 1'b0;
        jmp_load  = 1'b0;
        jmp_addr  = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = {2'b00, 14'(i + 1)};

        // Sequential 1-word fetch.
        en = 1'b1; ins_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) check_reset_outputs("rst");
            if (c == 1) begin
                check_eq("seq_first_rd",   32'(rom_rd),   32'h1);
                check_eq("seq_first_addr", 32'(rom_addr), 32'h0);
            end
            if (c == 1 || c == 2) check_eq("seq_early_valid", 32'(ins_valid), 32'h0);
            if (c >= 3) begin
                check_eq("seq_valid", 32'(ins_valid), 32'h1);
                check_eq("seq_pc",    32'(ins_pc),    32'(c - 3));
                check_eq("seq_word",  32'(ins_word),  32'(c - 2));
                check_eq("seq_len",   32'(ins_len),   32'h1);
            end
            next_cycle();
        end

        // 2-word assembly.
        save0 = mem[0]; save1 = mem[1];
        mem[0] = 16'h8123; mem[1] = 16'h00AA;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check_eq("w2_half_valid", 32'(ins_valid), 32'h0);
                check_eq("w2_half_cnt",   32'(q_count),   32'h1);
            end
            if (c == 4) begin
                check_eq("w2_valid", 32'(ins_valid), 32'h1);
                check_eq("w2_word",  32'(ins_word),  32'h8123);
                check_eq("w2_ext",   32'(ins_ext),   32'h00AA);
                check_eq("w2_len",   32'(ins_len),   32'h2);
                check_eq("w2_pc",    32'(ins_pc),    32'h0);
            end
            if (c == 5) begin
                check_eq("w2_next_pc",   32'(ins_pc),   32'h2);
                check_eq("w2_next_word", 32'(ins_word), 32'h0003);
                check_eq("w2_next_ext",  32'(ins_ext),  32'h0);
            end
            next_cycle();
        end
        mem[0] = save0; mem[1] = save1;

        // Backpressure: decoder stalls, queue fills and holds.
        ins_ready = 1'b0;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 6 || c == 10) begin
                check_eq("bp_cnt",   32'(q_count),   32'h4);
                check_eq("bp_rd",    32'(rom_rd),    32'h0);
                check_eq("bp_valid", 32'(ins_valid), 32'h1);
                check_eq("bp_pc",    32'(ins_pc),    32'h0);
                check_eq("bp_word",  32'(ins_word),  32'h0001);
            end
            next_cycle();
        end
        ins_ready = 1'b1;
        for (int c = 0; c < 14; c++) next_cycle();
        check_eq("bp_xfer_count", 32'(xq.size() >= 8), 32'h1);
        for (int i = 0; i < 8 && i < xq.size(); i++) begin
            check_eq("bp_xfer_pc",   32'(xq[i].pc),   32'(i));
            check_eq("bp_xfer_word", 32'(xq[i].word), 32'(i + 1));
        end

        // Redirect while the read of address 5 is outstanding.
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            jmp_load = (c == 7);
            jmp_addr = 16'h0040;
            @(negedge clk);
            if (c == 7) begin
                check_eq("jmp_cycle_rd",  32'(rom_rd),    32'h0);
                check_eq("jmp_cycle_pc",  32'(ins_pc),    32'h4);
                check_eq("jmp_cycle_vld", 32'(ins_valid), 32'h1);
            end
            if (c == 8) begin
                check_eq("jmp_rd",    32'(rom_rd),    32'h1);
                check_eq("jmp_addr",  32'(rom_addr),  32'h0040);
                check_eq("jmp_flush", 32'(ins_valid), 32'h0);
            end
            if (c == 10) begin
                check_eq("jmp_valid", 32'(ins_valid), 32'h1);
                check_eq("jmp_pc",    32'(ins_pc),    32'h0040);
            end
            next_cycle();
        end
        jmp_load = 1'b0;
        check_eq("jmp_xfer_count", 32'(xq.size() >= 7), 32'h1);
        if (xq.size() >= 7) begin
            check_eq("jmp_kept_pc",   32'(xq[4].pc), 32'h4);
            check_eq("jmp_after_pc",  32'(xq[5].pc), 32'h0040);
            check_eq("jmp_after_pc2", 32'(xq[6].pc), 32'h0041);
        end

        // Extension word wraps from FFFF to 0000.
        save0 = mem[0]; savef = mem[16'hFFFF];
        mem[16'hFFFF] = 16'h8000; mem[0] = 16'h1234;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            jmp_load = (c == 2);
            jmp_addr = 16'hFFFF;
            @(negedge clk);
            if (c == 3) begin
                check_eq("wrap_rd",   32'(rom_rd),   32'h1);
                check_eq("wrap_addr", 32'(rom_addr), 32'hFFFF);
            end
            if (c == 4) check_eq("wrap_addr_next", 32'(rom_addr), 32'h0000);
            if (c == 6) begin
                check_eq("wrap_valid", 32'(ins_valid), 32'h1);
                check_eq("wrap_pc",    32'(ins_pc),    32'hFFFF);
                check_eq("wrap_word",  32'(ins_word),  32'h8000);
                check_eq("wrap_ext",   32'(ins_ext),   32'h1234);
                check_eq("wrap_len",   32'(ins_len),   32'h2);
            end
            if (c == 7) check_eq("wrap_next_pc", 32'(ins_pc), 32'h0001);
            next_cycle();
        end
        jmp_load = 1'b0;
        check_eq("wrap_first_xfer", 32'(xq.size() >= 1 ? xq[0].pc : 16'h5A5A), 32'hFFFF);
        mem[0] = save0; mem[16'hFFFF] = savef;

        // en dropped with words queued: fetch stops, queue still drains.
        en = 1'b1; ins_ready = 1'b0;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            en        = (c < 3);
            ins_ready = (c >= 5);
            @(negedge clk);
            if (c == 4 || c == 8) check_eq("en_rd", 32'(rom_rd), 32'h0);
            if (c == 10) begin
                check_eq("en_drained_cnt", 32'(q_count),   32'h0);
                check_eq("en_drained_vld", 32'(ins_valid), 32'h0);
            end
            next_cycle();
        end
        check_eq("en_xfer_count", 32'(xq.size() >= 2), 32'h1);
        if (xq.size() >= 2) begin
            check_eq("en_xfer0_pc", 32'(xq[0].pc), 32'h0);
            check_eq("en_xfer1_pc", 32'(xq[1].pc), 32'h1);
        end

        // Reset mid-burst discards queue and in-flight read.
        en = 1'b1; ins_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            rst = (c == 5);
            @(negedge clk);
            if (c == 6) check_reset_outputs("midrst");
            if (c == 7) begin
                check_eq("midrst_inflight_cnt", 32'(q_count),   32'h0);
                check_eq("midrst_inflight_vld", 32'(ins_valid), 32'h0);
            end
            if (c == 9) begin
                check_eq("midrst_valid", 32'(ins_valid), 32'h1);
                check_eq("midrst_pc",    32'(ins_pc),    32'h0);
            end
            next_cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
